// File: rtl/gpr_scoreboard_if.sv
// Issue/completion bundle between the dual-issue front end and the GPR scoreboard.
// The pending-state outputs (busy, cnt, err) are registered inside the scoreboard.
interface gpr_scoreboard_if;
    logic        iss_valid0;
    logic        iss_valid1;
    logic [4:0]  iss_rs1_0;
    logic [4:0]  iss_rs2_0;
    logic [4:0]  iss_rd0;
    logic [4:0]  iss_rs1_1;
    logic [4:0]  iss_rs2_1;
    logic [4:0]  iss_rd1;
    logic        iss_wr0;
    logic        iss_wr1;
    logic        iss_long0;
    logic        iss_long1;
    logic        lng_we;
    logic [4:0]  lng_waddr;
    logic        flush;
    logic        stall0;
    logic        stall1;
    logic        fire0;
    logic        fire1;
    logic [30:0] busy;
    logic [2:0]  cnt;
    logic        err;

    modport master (
        output iss_valid0, iss_valid1,
        output iss_rs1_0, iss_rs2_0, iss_rd0,
        output iss_rs1_1, iss_rs2_1, iss_rd1,
        output iss_wr0, iss_wr1, iss_long0, iss_long1,
        output lng_we, lng_waddr, flush,
        input  stall0, stall1, fire0, fire1,
        input  busy, cnt, err
    );

    modport slave (
        input  iss_valid0, iss_valid1,
        input  iss_rs1_0, iss_rs2_0, iss_rd0,
        input  iss_rs1_1, iss_rs2_1, iss_rd1,
        input  iss_wr0, iss_wr1, iss_long0, iss_long1,
        input  lng_we, lng_waddr, flush,
        output stall0, stall1, fire0, fire1,
        output busy, cnt, err
    );
endinterface

// File: rtl/gpr_scoreboard.sv
// Dual-issue GPR scoreboard: tracks registers pending a long-latency write
// and stalls RAW/WAW hazards and long-unit overflow for an in-order pair.
module gpr_scoreboard #(
    parameter int LNG_DEPTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    gpr_scoreboard_if.slave sb
);
    logic [30:0] busy_q;
    logic [2:0]  cnt_q;
    logic        err_q;

    logic [30:0] busy_v;
    logic [2:0]  cnt_v;
    logic [30:0] done;
    logic [30:0] set;
    logic [31:0] eb;
    logic [2:0]  cnt_eff;
    logic [3:0]  room;
    logic        lg0;
    logic        lg1;
    logic        haz0;
    logic        haz1;
    logic        raw;
    logic        waw;
    logic        cap;
    logic        st0;
    logic        st1;
    logic        f0;
    logic        f1;
    logic [1:0]  nlong;

    // While in reset the hazard logic sees the cleared state, not stale flops.
    assign busy_v = rst_n ? busy_q : '0;
    assign cnt_v  = rst_n ? cnt_q : '0;

    always_comb begin
        done = '0;
        set  = '0;
        for (int i = 1; i < 32; i++) begin
            done[i-1] = sb.lng_we && (sb.lng_waddr == 5'(i));
            set[i-1]  = (f0 && lg0 && (sb.iss_rd0 == 5'(i)))
                     || (f1 && lg1 && (sb.iss_rd1 == 5'(i)));
        end
    end

    // A completing write is forwarded this cycle, so it no longer blocks.
    assign eb      = {busy_v & ~done, 1'b0};
    assign cnt_eff = cnt_v - {2'b00, sb.lng_we && (cnt_v != 3'd0)};
    assign room    = 4'(LNG_DEPTH) - {1'b0, cnt_eff};

    assign lg0 = sb.iss_wr0 && sb.iss_long0 && (sb.iss_rd0 != 5'd0);
    assign lg1 = sb.iss_wr1 && sb.iss_long1 && (sb.iss_rd1 != 5'd0);

    assign haz0 = eb[sb.iss_rs1_0] || eb[sb.iss_rs2_0]
               || (sb.iss_wr0 && eb[sb.iss_rd0])
               || (lg0 && (room == 4'd0));
    assign haz1 = eb[sb.iss_rs1_1] || eb[sb.iss_rs2_1]
               || (sb.iss_wr1 && eb[sb.iss_rd1])
               || (lg1 && (room == 4'd0));

    assign raw = sb.iss_valid0 && sb.iss_wr0 && (sb.iss_rd0 != 5'd0)
              && ((sb.iss_rd0 == sb.iss_rs1_1) || (sb.iss_rd0 == sb.iss_rs2_1));
    assign waw = sb.iss_valid0 && lg0 && (sb.iss_rd0 == sb.iss_rd1);
    assign cap = sb.iss_valid0 && lg0 && lg1 && (room < 4'd2);

    assign st0 = sb.flush || (sb.iss_valid0 && haz0);
    assign st1 = sb.flush || (sb.iss_valid1
              && ((sb.iss_valid0 && st0) || haz1 || raw || waw || cap));
    assign f0  = sb.iss_valid0 && !st0;
    assign f1  = sb.iss_valid1 && !st1;

    assign nlong = {1'b0, f0 && lg0} + {1'b0, f1 && lg1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else if (sb.flush) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= (busy_q & ~done) | set;
            cnt_q  <= cnt_eff + {1'b0, nlong};
            err_q  <= err_q || (sb.lng_we && (cnt_q == 3'd0));
        end
    end

    assign sb.stall0 = st0;
    assign sb.stall1 = st1;
    assign sb.fire0  = f0;
    assign sb.fire1  = f1;
    assign sb.busy   = busy_q;
    assign sb.cnt    = cnt_q;
    assign sb.err    = err_q;
endmodule

// File: tb/tb_gpr_scoreboard.sv
// Random and directed stimulus for gpr_scoreboard against a set/count
// reference model of pending long-latency destinations.
module tb_gpr_scoreboard;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gpr_scoreboard_if sb ();
    gpr_scoreboard #(.LNG_DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .sb(sb));

    bit m_pend[32];
    int m_cnt;
    bit m_err;
    int n_vec;
    int n_bad;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        sb.iss_valid0 = 0; sb.iss_valid1 = 0;
        sb.iss_rs1_0 = 0; sb.iss_rs2_0 = 0; sb.iss_rd0 = 0;
        sb.iss_rs1_1 = 0; sb.iss_rs2_1 = 0; sb.iss_rd1 = 0;
        sb.iss_wr0 = 0; sb.iss_wr1 = 0;
        sb.iss_long0 = 0; sb.iss_long1 = 0;
        sb.lng_we = 0; sb.lng_waddr = 0; sb.flush = 0;
    endtask

    // Called just after a falling edge with inputs driven; returns at the next falling edge.
    task automatic apply();
        bit eb[32];
        int c, nl;
        bit l0, l1, h0, h1, s0, s1, f0, f1;
        logic [30:0] pk;
        #1;
        for (int r = 0; r < 32; r++)
            eb[r] = (r != 0) && rst_n && m_pend[r]
                 && !(sb.lng_we && sb.lng_waddr == r);
        c = rst_n ? m_cnt : 0;
        if (sb.lng_we && c > 0) c--;
        l0 = sb.iss_wr0 && sb.iss_long0 && sb.iss_rd0 != 0;
        l1 = sb.iss_wr1 && sb.iss_long1 && sb.iss_rd1 != 0;
        h0 = eb[sb.iss_rs1_0] || eb[sb.iss_rs2_0]
          || (sb.iss_wr0 && eb[sb.iss_rd0]) || (l0 && c == D);
        h1 = eb[sb.iss_rs1_1] || eb[sb.iss_rs2_1]
          || (sb.iss_wr1 && eb[sb.iss_rd1]) || (l1 && c == D);
        s0 = sb.flush || (sb.iss_valid0 && h0);
        s1 = sb.flush || (sb.iss_valid1 && (
               (sb.iss_valid0 && s0) || h1
            || (sb.iss_valid0 && sb.iss_wr0 && sb.iss_rd0 != 0
                && (sb.iss_rd0 == sb.iss_rs1_1 || sb.iss_rd0 == sb.iss_rs2_1))
            || (sb.iss_valid0 && l0 && sb.iss_rd0 == sb.iss_rd1)
            || (sb.iss_valid0 && l0 && l1 && c + 2 > D)));
        f0 = sb.iss_valid0 && !s0;
        f1 = sb.iss_valid1 && !s1;
        for (int r = 1; r < 32; r++) pk[r-1] = m_pend[r];
        check("stall0", 32'(sb.stall0), 32'(s0));
        check("stall1", 32'(sb.stall1), 32'(s1));
        check("fire0", 32'(sb.fire0), 32'(f0));
        check("fire1", 32'(sb.fire1), 32'(f1));
        check("busy", 32'(sb.busy), 32'(pk));
        check("cnt", 32'(sb.cnt), 32'(m_cnt));
        check("err", 32'(sb.err), 32'(m_err));
        check("cnt_bound", 32'(sb.cnt <= 3'(D)), 32'd1);
        @(posedge clk);
        if (!rst_n) begin
            foreach (m_pend[r]) m_pend[r] = 0;
            m_cnt = 0;
            m_err = 0;
        end else if (sb.flush) begin
            foreach (m_pend[r]) m_pend[r] = 0;
            m_cnt = 0;
        end else begin
            if (sb.lng_we && m_cnt == 0) m_err = 1;
            if (sb.lng_we) m_pend[sb.lng_waddr] = 0;
            nl = 0;
            if (f0 && l0) begin m_pend[sb.iss_rd0] = 1; nl++; end
            if (f1 && l1) begin m_pend[sb.iss_rd1] = 1; nl++; end
            m_pend[0] = 0;
            m_cnt = c + nl;
        end
        @(negedge clk);
    endtask

    task automatic rnd();
        int q[$];
        idle();
        sb.iss_valid0 = 1'($urandom);
        sb.iss_valid1 = 1'($urandom);
        sb.iss_rs1_0 = 5'($urandom_range(0, 7));
        sb.iss_rs2_0 = 5'($urandom_range(0, 7));
        sb.iss_rd0   = 5'($urandom_range(0, 7));
        sb.iss_rs1_1 = 5'($urandom_range(0, 7));
        sb.iss_rs2_1 = 5'($urandom_range(0, 7));
        sb.iss_rd1   = 5'($urandom_range(0, 7));
        sb.iss_wr0   = 1'($urandom);
        sb.iss_wr1   = 1'($urandom);
        sb.iss_long0 = sb.iss_wr0 & ($urandom_range(0, 2) != 0);
        sb.iss_long1 = sb.iss_wr1 & ($urandom_range(0, 2) != 0);
        for (int r = 1; r < 32; r++) if (m_pend[r]) q.push_back(r);
        if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
            sb.lng_we = 1;
            sb.lng_waddr = 5'(q[$urandom_range(0, q.size() - 1)]);
        end else if ($urandom_range(0, 80) == 0) begin
            sb.lng_we = 1;
            sb.lng_waddr = 5'($urandom_range(0, 31));
        end
        sb.flush = ($urandom_range(0, 24) == 0);
        rst_n = ($urandom_range(0, 149) != 0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        m_cnt = 0;
        m_err = 0;
        foreach (m_pend[r]) m_pend[r] = 0;
        idle();
        rst_n = 0;
        @(negedge clk);
        apply();
        apply();
        rst_n = 1;
        // Long op on x5, dependent read, same-cycle completion
        sb.iss_valid0 = 1; sb.iss_wr0 = 1; sb.iss_long0 = 1; sb.iss_rd0 = 5;
        apply();
        idle(); sb.iss_valid0 = 1; sb.iss_rs1_0 = 5;
        apply();
        check("dir_busy_x5", 32'(sb.busy[4]), 32'd1);
        sb.lng_we = 1; sb.lng_waddr = 5;
        apply();
        idle();
        apply();
        check("dir_clear_x5", 32'(sb.busy[4]), 32'd0);
        // Intra-pair RAW through x7
        sb.iss_valid0 = 1; sb.iss_wr0 = 1; sb.iss_rd0 = 7;
        sb.iss_valid1 = 1; sb.iss_rs2_1 = 7;
        apply();
        idle(); sb.iss_valid1 = 1; sb.iss_rs2_1 = 7;
        apply();
        // Spurious completion sets err; flush keeps it
        idle(); sb.lng_we = 1; sb.lng_waddr = 3;
        apply();
        idle(); sb.flush = 1;
        apply();
        idle();
        apply();
        check("dir_err_sticky", 32'(sb.err), 32'd1);
        rst_n = 0;
        apply();
        rst_n = 1;
        for (int i = 0; i < 3000; i++) begin
            rnd();
            apply();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
